// File: rtl/nios2_mult_pkg.sv
// Shared mode encodings and operand-signedness decode for the pipelined multiplier.
package nios2_mult_pkg;

  localparam logic [1:0] MODE_MUL    = 2'b00;
  localparam logic [1:0] MODE_MULXSS = 2'b01;
  localparam logic [1:0] MODE_MULXSU = 2'b10;
  localparam logic [1:0] MODE_MULXUU = 2'b11;

  function automatic logic is_signed_a(input logic [1:0] mode);
    return (mode == MODE_MULXSS) || (mode == MODE_MULXSU);
  endfunction

  function automatic logic is_signed_b(input logic [1:0] mode);
    return (mode == MODE_MULXSS);
  endfunction

endpackage

// File: rtl/nios2_mult_partial.sv
// One registered signed (H+1)x(H+1) partial-product multiplier with load enable.
module nios2_mult_partial #(
  parameter int H = 16
) (
  input  logic           clk,
  input  logic           i_en,
  input  logic [H:0]     i_a,
  input  logic [H:0]     i_b,
  output logic [2*H+1:0] o_p
);

  logic [2*H+1:0] r_p;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_p <= $signed(i_a) * $signed(i_b);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/nios2_mult_pipe.sv
// Three-stage W x W multiplier: S1 partial products, S2 accumulate, S3 word select.
// Returns the low word (MUL) or the high word (MULXSS / MULXSU / MULXUU).
module nios2_mult_pipe
  import nios2_mult_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_src1,
  input  logic [W-1:0]     in_src2,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int H = W / 2;

  // Handshake: an operation transfers on a rising edge where in_valid && in_ready,
  // a result transfers where out_valid && out_ready. The whole pipe moves as one
  // (w_adv); a flush kills every stage valid, including the op offered that cycle.
  logic w_adv;
  assign w_adv    = out_ready || !out_valid;
  assign in_ready = w_adv;

  logic           w_sa;
  logic           w_sb;
  logic [H:0]     w_a_lo;
  logic [H:0]     w_a_hi;
  logic [H:0]     w_b_lo;
  logic [H:0]     w_b_hi;

  assign w_sa   = is_signed_a(in_mode);
  assign w_sb   = is_signed_b(in_mode);
  assign w_a_lo = {1'b0, in_src1[H-1:0]};
  assign w_b_lo = {1'b0, in_src2[H-1:0]};
  assign w_a_hi = {w_sa & in_src1[W-1], in_src1[W-1:H]};
  assign w_b_hi = {w_sb & in_src2[W-1], in_src2[W-1:H]};

  logic [W+1:0] w_p_ll;
  logic [W+1:0] w_p_lh;
  logic [W+1:0] w_p_hl;
  logic [W+1:0] w_p_hh;

  nios2_mult_partial #(.H(H)) u_pll (.clk(clk), .i_en(w_adv), .i_a(w_a_lo), .i_b(w_b_lo), .o_p(w_p_ll));
  nios2_mult_partial #(.H(H)) u_plh (.clk(clk), .i_en(w_adv), .i_a(w_a_lo), .i_b(w_b_hi), .o_p(w_p_lh));
  nios2_mult_partial #(.H(H)) u_phl (.clk(clk), .i_en(w_adv), .i_a(w_a_hi), .i_b(w_b_lo), .o_p(w_p_hl));
  nios2_mult_partial #(.H(H)) u_phh (.clk(clk), .i_en(w_adv), .i_a(w_a_hi), .i_b(w_b_hi), .o_p(w_p_hh));

  // Partial products are signed; sign-extend to 2W so the sum wraps correctly.
  logic [2*W-1:0] w_ext_ll;
  logic [2*W-1:0] w_ext_lh;
  logic [2*W-1:0] w_ext_hl;
  logic [2*W-1:0] w_ext_hh;
  logic [2*W-1:0] w_prod;

  assign w_ext_ll = {{(W-2){w_p_ll[W+1]}}, w_p_ll};
  assign w_ext_lh = {{(W-2){w_p_lh[W+1]}}, w_p_lh};
  assign w_ext_hl = {{(W-2){w_p_hl[W+1]}}, w_p_hl};
  assign w_ext_hh = {{(W-2){w_p_hh[W+1]}}, w_p_hh};
  assign w_prod   = w_ext_ll + (w_ext_lh << H) + (w_ext_hl << H) + (w_ext_hh << (2 * H));

  logic             r_s1_valid;
  logic [1:0]       r_s1_mode;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  logic [1:0]       r_s2_mode;
  logic [TAG_W-1:0] r_s2_tag;
  logic [2*W-1:0]   r_s2_prod;
  logic             r_out_valid;
  logic [W-1:0]     r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  logic [W-1:0] w_sel;
  assign w_sel = (r_s2_mode == MODE_MUL) ? r_s2_prod[W-1:0] : r_s2_prod[2*W-1:W];

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_mode <= in_mode;
      r_s1_tag  <= in_tag;
      r_s2_mode <= r_s1_mode;
      r_s2_tag  <= r_s1_tag;
      r_s2_prod <= w_prod;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else begin
      if (w_adv) begin
        r_s1_valid   <= in_valid;
        r_s2_valid   <= r_s1_valid;
        r_out_valid  <= r_s2_valid;
        r_out_result <= w_sel;
        r_out_tag    <= r_s2_tag;
      end
      if (flush) begin
        r_s1_valid  <= 1'b0;
        r_s2_valid  <= 1'b0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Directed bench for nios2_mult_pipe at W=32/TAG_W=5 plus a W=16/TAG_W=1 instance.
module tb_nios2_mult_pipe;

  localparam int W   = 32;
  localparam int TW  = 5;
  localparam int W2  = 16;
  localparam int TW2 = 1;

  localparam logic [1:0] M_MUL = 2'b00;
  localparam logic [1:0] M_XSS = 2'b01;
  localparam logic [1:0] M_XSU = 2'b10;
  localparam logic [1:0] M_XUU = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- W=32 instance ----------------
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0]  in_src1, in_src2, out_result;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag, out_tag;

  nios2_mult_pipe #(.W(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_mode(in_mode), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  // ---------------- W=16 instance ----------------
  logic           s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [W2-1:0]  s_in_src1, s_in_src2, s_out_result;
  logic [1:0]     s_in_mode;
  logic [TW2-1:0] s_in_tag, s_out_tag;

  nios2_mult_pipe #(.W(W2), .TAG_W(TW2)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_src1(s_in_src1), .in_src2(s_in_src2), .in_mode(s_in_mode), .in_tag(s_in_tag),
    .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_result(s_out_result), .out_tag(s_out_tag)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int n_recv = 0;
  logic [TW+W-1:0] exp_q[$];
  logic [TW+W-1:0] pending_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: extend to 2W+2 bits by signedness and multiply.
  function automatic logic [W-1:0] ref_mul(input logic [1:0] mode, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [2*W+1:0] ea, eb, p;
    logic sa, sb;
    sa = (mode == M_XSS) || (mode == M_XSU);
    sb = (mode == M_XSS);
    ea = sa ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    eb = sb ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    p  = ea * eb;
    return (mode == M_MUL) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input logic [W-1:0] exp_res);
    in_valid    = 1'b1;
    in_mode     = mode;
    in_src1     = a;
    in_src2     = b;
    in_tag      = tag;
    pending_exp = {tag, exp_res};
  endtask

  // Check a result handed over this cycle, log an accepted op, advance one clock.
  task automatic tick(output logic acc);
    logic [TW+W-1:0] e;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("result", out_result, e[W-1:0]);
        chk("tag", out_tag, e[TW+W-1:W]);
        n_recv++;
      end
    end
    acc = in_valid && in_ready && !flush;
    if (acc) exp_q.push_back(pending_exp);
    @(negedge clk);
  endtask

  task automatic single(input logic [1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input logic [W-1:0] exp_res);
    logic acc;
    drive_op(mode, a, b, tag, exp_res);
    tick(acc);
    chk("single_accept", acc, 1);
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("latency_valid", out_valid, (k == 3));
      tick(acc);
    end
    #1;
    chk("valid_one_cycle", out_valid, 0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   n_sent, cyc, base;
    logic [1:0]     sm[4];
    logic [W2-1:0]  sa[4], sb[4], sr[4];
    logic [TW2-1:0] st[4];

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_src1 = '0; in_src2 = '0; in_mode = M_MUL; in_tag = '0; pending_exp = '0;
    s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;
    s_in_src1 = '0; s_in_src2 = '0; s_in_mode = M_MUL; s_in_tag = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset16_out_valid", s_out_valid, 0);
    chk("reset16_out_result", s_out_result, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed words
    single(M_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001);
    single(M_XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE);
    single(M_XSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000);
    single(M_XSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
    single(M_XSS, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000);
    single(M_XSS, 32'h8000_0000, 32'h0000_0002, 5'd8, 32'hFFFF_FFFF);
    single(M_MUL, 32'h0001_2345, 32'h0001_0000, 5'd31, 32'h2345_0000);

    // Stream of 10 ops with a 4-cycle output stall in the middle
    base = n_recv;
    n_sent = 0;
    cyc = 0;
    in_src1 = $urandom; in_src2 = $urandom; in_mode = 2'($urandom_range(0, 3));
    drive_op(in_mode, in_src1, in_src2, 5'($urandom_range(0, 31)), ref_mul(in_mode, in_src1, in_src2));
    while ((n_sent < 10 || exp_q.size() != 0) && cyc < 100) begin
      out_ready = !(cyc >= 6 && cyc < 10);
      if (!out_ready) begin
        #1;
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        if (exp_q.size() != 0) chk("stall_hold", {out_tag, out_result}, exp_q[0]);
        else chk("stall_queue_empty", exp_q.size(), 1);
      end
      tick(acc);
      if (acc) begin
        n_sent++;
        if (n_sent < 10) begin
          in_src1 = $urandom; in_src2 = $urandom; in_mode = 2'($urandom_range(0, 3));
          drive_op(in_mode, in_src1, in_src2, 5'($urandom_range(0, 31)),
                   ref_mul(in_mode, in_src1, in_src2));
        end else begin
          in_valid = 1'b0;
        end
      end
      cyc++;
    end
    out_ready = 1'b1;
    chk("stream_count", n_recv - base, 10);
    chk("stream_cycles", cyc, 17);

    // Flush with a 4th op presented alongside
    drive_op(M_MUL, 32'd3, 32'd5, 5'd1, 32'd15);  tick(acc);
    drive_op(M_MUL, 32'd7, 32'd9, 5'd2, 32'd63);  tick(acc);
    drive_op(M_XUU, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'd1); tick(acc);
    drive_op(M_MUL, 32'd11, 32'd13, 5'd4, 32'd143);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1);
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("flush_no_out", out_valid, 0);
      @(negedge clk);
    end
    single(M_XUU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, ref_mul(M_XUU, 32'h1234_5678, 32'h9ABC_DEF0));

    // Reset with two ops in flight
    drive_op(M_MUL, 32'd2, 32'd2, 5'd10, 32'd4); tick(acc);
    drive_op(M_MUL, 32'd3, 32'd3, 5'd11, 32'd9); tick(acc);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_result", out_result, 0);
    chk("midreset_out_tag", out_tag, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("postreset_no_out", out_valid, 0);
      @(negedge clk);
    end
    single(M_XSU, 32'h0000_0010, 32'hFFFF_FFFF, 5'd12, 32'h0000_000F);

    // W=16 instance: four ops back to back
    sm[0] = M_XSU; sa[0] = 16'hFFFF; sb[0] = 16'hFFFF; st[0] = 1'b1; sr[0] = 16'hFFFF;
    sm[1] = M_MUL; sa[1] = 16'hFFFF; sb[1] = 16'hFFFF; st[1] = 1'b0; sr[1] = 16'h0001;
    sm[2] = M_XUU; sa[2] = 16'hFFFF; sb[2] = 16'hFFFF; st[2] = 1'b1; sr[2] = 16'hFFFE;
    sm[3] = M_XSS; sa[3] = 16'h8000; sb[3] = 16'h8000; st[3] = 1'b0; sr[3] = 16'h4000;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        s_in_valid = 1'b1; s_in_mode = sm[c]; s_in_src1 = sa[c]; s_in_src2 = sb[c]; s_in_tag = st[c];
      end else begin
        s_in_valid = 1'b0;
      end
      #1;
      if (c >= 3 && c < 7) begin
        chk("w16_valid", s_out_valid, 1);
        chk("w16_result", s_out_result, sr[c-3]);
        chk("w16_tag", s_out_tag, st[c-3]);
      end else begin
        chk("w16_idle", s_out_valid, 0);
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios2_mult_pipe.md
Name: nios2_mult_pipe

Overview:
- Parametrised successor to the CPU's three-partial-product multiply cell.
- Computes the full 2W-bit product of two W-bit operands internally from four half-width partial products, then returns either the low W bits or the high W bits.
- High-word results support signed×signed, signed×unsigned and unsigned×unsigned operation.
- Sits between the CPU execute stage and writeback, with a valid/ready handshake, a tag pass-through and a flush.

Parameters:
- W, 32: operand and result width. Must be even and ≥8. H = W/2.
- TAG_W, 5: width of the opaque tag carried alongside each operation (destination register index).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  operation accepted this cycle when in_valid && in_ready
- in_src1  in  W  operand A
- in_src2  in  W  operand B
- in_mode  in  2  00 MUL (low word); 01 MULXSS; 10 MULXSU (A signed, B unsigned); 11 MULXUU
- in_tag  in  TAG_W  tag returned with the result
- flush  in  1  kill all in-flight operations
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  W  selected product word
- out_tag  out  TAG_W  tag of the result

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset; all state updates on the rising edge of clk.
- Reset: all stage valids = 0, so out_valid = 0. out_result = 0 and out_tag = 0 on reset. Data registers need not be reset except the output stage.
- Pipeline: three stages, S1 → S2 → S3, so latency is exactly 3 cycles from acceptance to out_valid when there is no stall.
- Global advance: adv = out_ready || !out_valid. All stages load only when adv = 1; in_ready = adv.
- Stage registers hold their contents when adv = 0. No bubble-collapsing is required.
- S1 (operand split and partial products):
  - aL, bL are zero-extended to H+1 bits.
  - aH, bH are extended to H+1 bits with the operand's MSB when that operand is signed for the mode (MULXSS: A and B; MULXSU: A only). Otherwise they are zero-extended.
  - MUL treats both operands as unsigned; the low word is identical for either signedness.
  - Registered results: pLL = aL*bL, pLH = aL*bH, pHL = aH*bL, pHH = aH*bH. Each is a signed (H+1)×(H+1) product held at 2H+2 bits.
  - Mode and tag are registered alongside.
- S2 (accumulate): prod = pLL + (pLH << H) + (pHL << H) + (pHH << 2H), computed in 2W bits with sign-extended terms and wrap at 2W bits.
- S3 (select and output): out_result = MUL ? prod[W-1:0] : prod[2W-1:W]. out_tag is registered; out_valid is the S2 valid when adv = 1.
- flush:
  - Synchronously clears the S1, S2 and S3 valids on the same edge.
  - Overrides any acceptance on that cycle, so the operation presented alongside flush is dropped.
  - in_ready is unaffected by flush.
- Stall: while out_valid && !out_ready, out_result and out_tag stay stable and no new operation is accepted.
- Reset asserted mid-operation discards all in-flight operations. The first accept after reset deasserts produces a result exactly 3 cycles later.
- Back-to-back: one result per cycle is sustained when out_ready = 1 continuously.

Decomposition:
- Package nios2_mult_pkg holds:
  - mode localparams MODE_MUL = 2'b00, MODE_MULXSS = 2'b01, MODE_MULXSU = 2'b10, MODE_MULXUU = 2'b11;
  - function is_signed_a(mode) and function is_signed_b(mode).
- Sub-module nios2_mult_partial: one registered signed (H+1)×(H+1) multiplier with an enable. It is instantiated four times in S1 and maps to the dedicated multiplier blocks.

Test Plan:
- Reset then MUL 0xFFFFFFFF×0xFFFFFFFF, tag 3 → exactly 3 cycles later out_result = 0x00000001, out_tag = 3. out_valid is high for 1 cycle with out_ready = 1.
- Same operands in MULXUU / MULXSS / MULXSU → 0xFFFFFFFE / 0x00000000 / 0xFFFFFFFF.
- MULXSS 0x80000000×0x80000000 → 0x40000000; MULXSS 0x80000000×0x00000002 → 0xFFFFFFFF; MUL 0x00012345×0x00010000 → 0x23450000.
- Stream 10 random operations with out_ready = 1 → 10 consecutive valid results matching the reference model. Then hold out_ready = 0 for 4 cycles mid-stream → output stable, in_ready = 0, no loss or duplication.
- Accept 3 operations, assert flush on the cycle a 4th is presented → no results emerge. Next accepted operation appears 3 cycles later.
- Assert reset for 1 cycle with 2 operations in flight → out_valid = 0 and out_result = 0 next cycle, nothing emerges. Repeat the scenarios with W = 16, TAG_W = 1: MULXSU 0xFFFF×0xFFFF → 0xFFFF.
